// File: rtl/riscv_multicycle_ctrl_pkg.sv
// riscv_multicycle_ctrl_pkg: shared opcodes, state codes, mux selects and decode helper
package riscv_multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BR_IMM = 2'b11;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC    = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    // Dispatch target after DECODE; anything unsupported traps
    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEM_ADR;
            OP_R, OP_I:        return S_EXEC;
            OP_BEQ:            return S_BRANCH;
            OP_JAL:            return S_JAL;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_timer.sv
// riscv_multicycle_ctrl_timer: memory wait counter flagging the last permitted wait cycle
module riscv_multicycle_ctrl_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] cnt;

    // Count wait cycles; clear has priority so each access starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= cnt + TW'(1);
    end

    assign expired = cnt == TW'(MEM_TIMEOUT - 1);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: main control FSM for the multicycle RISC-V datapath
module riscv_multicycle_ctrl
    import riscv_multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       instr_retired,
    output logic [3:0] state_o
);

    state_t state, state_next;
    logic   waiting, expired, timeout;

    // A memory access is outstanding only in these states; the counter idles at zero elsewhere
    assign waiting = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign timeout = waiting && expired && !mem_ready;
    assign state_o = state;

    riscv_multicycle_ctrl_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TW         (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!waiting || mem_ready || expired),
        .enable (waiting && !mem_ready),
        .expired(expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_next;
    end

    // Next-state and control decode; a timeout drops the request and re-fetches
    always_comb begin
        state_next    = S_RST;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = WB_ALUOUT;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PC_SRC_ALU;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        instr_retired = 1'b0;
        case (state)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                bus_error  = timeout;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_BR_IMM;
                state_next = decode_target(opcode);
            end
            S_MEM_ADR: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                state_next = opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord       = 1'b1;
                mem_read   = 1'b1;
                bus_error  = timeout;
                state_next = mem_ready ? S_MEM_WB : timeout ? S_FETCH : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = WB_MDR;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEM_WR: begin
                iord          = 1'b1;
                mem_write     = 1'b1;
                instr_retired = mem_ready;
                bus_error     = timeout;
                state_next    = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = opcode == OP_R ? SRC_B_REG : SRC_B_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRC_A_REG;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                reg_write     = 1'b1;
                mem_to_reg    = WB_PC;
                pc_write      = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_retired = 1'b1;
                state_next    = S_FETCH;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_next    = S_FETCH;
            end
            default: state_next = S_RST;
        endcase
    end

endmodule
